mux_arb_nx1: RTL and testbench



---
 rtl/mux_arb_nx1_if.sv | 24 ++
 rtl/mux_arb_nx1.sv | 77 +++++++
 tb/tb_mux_arb_nx1.sv | 114 +++++++++++
 3 files changed

// File: rtl/mux_arb_nx1_if.sv
// mux_arb_nx1_if: channel inputs, select controls and registered output of the N:1 mux/arbiter
interface mux_arb_nx1_if #(
  parameter int DATA_WIDTH = 1,
  parameter int NUM_CH = 8,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
);
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_ready;
  logic mode;
  logic [SEL_WIDTH-1:0] select;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [SEL_WIDTH-1:0] out_channel;
  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input in_ready, out_data, out_valid, out_channel
  );
  modport slave (
    input in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_valid, out_channel
  );
endinterface

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1: registered N:1 mux with direct-select or round-robin arbitration.
// Define MUX_ARB_BURST_EN to let a round-robin winner keep the grant for up to BURST_LEN transfers.
module mux_arb_nx1 #(
  parameter int DATA_WIDTH = 1,
  parameter int NUM_CH = 8,
  parameter int SEL_WIDTH = $clog2(NUM_CH),
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic reset_n,
  mux_arb_nx1_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [SEL_WIDTH-1:0] rr_ptr, gnt, idx, ch_q;
  logic [NUM_CH-1:0] gnt_hot, rr_hot, rdy;
  logic [DATA_WIDTH-1:0] gnt_data, dat_q;
  logic load, xfer, hold;
`ifdef MUX_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  logic [CW-1:0] cnt;
  assign hold = cnt != '0 && cnt < CW'(BURST_LEN) && bus.in_valid[rr_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (xfer) cnt <= bus.mode ? (hold ? cnt + 1'b1 : CW'(1)) : '0;
    else if (!bus.in_valid[rr_ptr]) cnt <= '0;
`else
  assign hold = 1'b0;
`endif
  // search downward so the nearest valid channel after rr_ptr is written last
  always_comb begin
    idx = '0;
    rr_hot = '0;
    if (hold) rr_hot[rr_ptr] = 1'b1;
    else
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = SEL_WIDTH'((int'(rr_ptr) + k) % NUM_CH);
        if (bus.in_valid[idx]) begin
          rr_hot = '0;
          rr_hot[idx] = 1'b1;
        end
      end
    gnt_hot = '0;
    gnt = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_hot[i] = bus.mode ? rr_hot[i] : bus.select == SEL_WIDTH'(i);
      if (gnt_hot[i]) begin
        gnt = SEL_WIDTH'(i);
        gnt_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    load = state == EMPTY || bus.out_ready;
    rdy = reset_n && load ? gnt_hot : '0;
    xfer = |(rdy & bus.in_valid);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= EMPTY;
    else state <= state_nx;
  always_comb state_nx = xfer ? FULL : (bus.out_ready ? EMPTY : state);
  always_comb begin
    bus.out_valid = state == FULL;
    bus.out_data = dat_q;
    bus.out_channel = ch_q;
    bus.in_ready = rdy;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dat_q <= '0;
      ch_q <= '0;
      rr_ptr <= SEL_WIDTH'(NUM_CH - 1);
    end else if (xfer) begin
      dat_q <= gnt_data;
      ch_q <= gnt;
      if (bus.mode) rr_ptr <= gnt;
    end
endmodule

// File: tb/tb_mux_arb_nx1.sv
// tb_mux_arb_nx1: directed table plus hand sequences for the 8x8 mux/arbiter.
module tb_mux_arb_nx1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  mux_arb_nx1_if #(.DATA_WIDTH(8), .NUM_CH(8)) bus ();
  mux_arb_nx1 #(.DATA_WIDTH(8), .NUM_CH(8), .BURST_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic m; logic [2:0] s; logic [7:0] v; logic r;
    logic [7:0] er; logic ev; logic [7:0] ed; logic [2:0] ec;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic m, input logic [2:0] s, input logic [7:0] v, input logic r);
    bus.mode = m;
    bus.select = s;
    bus.in_valid = v;
    bus.out_ready = r;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  // one cycle: apply inputs, check combinational ready, clock, check the register
  task automatic step(input string nm, input logic m, input logic [2:0] s, input logic [7:0] v,
                      input logic r, input logic [7:0] er, input logic ev, input logic [2:0] ec);
    drive(m, s, v, r);
    #3 chk({nm, " in_ready"}, 32'(bus.in_ready), 32'(er));
    @(posedge clk);
    #1 chk({nm, " out_valid"}, 32'(bus.out_valid), 32'(ev));
    if (ev) begin
      chk({nm, " out_channel"}, 32'(bus.out_channel), 32'(ec));
      chk({nm, " out_data"}, 32'(bus.out_data), 32'(8'hA0 | 8'(ec)));
    end
  endtask
  logic [2:0] exp_ch, held_ch;
  logic [7:0] held_data;
  initial begin
    tbl[0] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 8'hA0, 3'd0};
    tbl[1] = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 8'hA5, 3'd5};
    tbl[2] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 8'hA1, 3'd1};
    tbl[3] = '{1'b0, 3'd2, 8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 3'd0};
    tbl[4] = '{1'b0, 3'd3, 8'h08, 1'b0, 8'h08, 1'b1, 8'hA3, 3'd3};
    tbl[5] = '{1'b0, 3'd3, 8'h08, 1'b0, 8'h00, 1'b1, 8'hA3, 3'd3};
    tbl[6] = '{1'b1, 3'd3, 8'h48, 1'b0, 8'h00, 1'b1, 8'hA3, 3'd3};
    tbl[7] = '{1'b1, 3'd3, 8'h48, 1'b1, 8'h08, 1'b1, 8'hA3, 3'd3};
    for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = 8'hA0 | 8'(i);
    drive(1'b1, 3'd0, 8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_data", 32'(bus.out_data), 0);
    chk("rst in_ready", 32'(bus.in_ready), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].r);
      #3 chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].er));
      @(posedge clk);
      #1 chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(tbl[i].ed));
        chk($sformatf("row%0d out_channel", i), 32'(bus.out_channel), 32'(tbl[i].ec));
      end
    end
    do_reset();
    for (int i = 0; i < 9; i++) begin
`ifdef MUX_ARB_BURST_EN
      exp_ch = 3'(i / 4);
`else
      exp_ch = 3'(i % 8);
`endif
      step($sformatf("rr%0d", i), 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01 << exp_ch, 1'b1, exp_ch);
    end
    held_ch = exp_ch;
    held_data = 8'hA0 | 8'(exp_ch);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'(1 + 2 * i), 8'hFF, 1'b0);
      #3 chk($sformatf("bp%0d in_ready", i), 32'(bus.in_ready), 0);
      @(posedge clk);
      #1 chk($sformatf("bp%0d out_data", i), 32'(bus.out_data), 32'(held_data));
      chk($sformatf("bp%0d out_channel", i), 32'(bus.out_channel), 32'(held_ch));
      chk($sformatf("bp%0d out_valid", i), 32'(bus.out_valid), 1);
    end
    step("drain_load", 1'b0, 3'd2, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2);
    do_reset();
    step("wrap_pre6", 1'b1, 3'd0, 8'h40, 1'b1, 8'h40, 1'b1, 3'd6);
    step("wrap_gap0", 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
    step("wrap_g3a", 1'b1, 3'd0, 8'h48, 1'b1, 8'h08, 1'b1, 3'd3);
    step("wrap_gap1", 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
    step("wrap_g6", 1'b1, 3'd0, 8'h48, 1'b1, 8'h40, 1'b1, 3'd6);
    step("wrap_gap2", 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
    step("wrap_g3b", 1'b1, 3'd0, 8'h48, 1'b1, 8'h08, 1'b1, 3'd3);
    drive(1'b1, 3'd0, 8'hFF, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk("arst out_valid", 32'(bus.out_valid), 0);
    chk("arst out_data", 32'(bus.out_data), 0);
    chk("arst in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("post_arst", 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
